// File: rtl/xmaxmin_sched.sv
// xmaxmin_sched: round-robin arbiter that streams one requester's frame at a time
// into the shared max/min search engine and tags each engine result with its owner.
module xmaxmin_sched #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int BWID       = 16,
    parameter int BWID_INDEX = 10
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      iv_req,
    output logic [NREQ-1:0]      ov_gnt,
    input  logic [NREQ*BWID-1:0] iv_data,
    input  logic [NREQ-1:0]      iv_valid,
    input  logic [NREQ-1:0]      iv_last,
    output logic [NREQ-1:0]      ov_ready,
    output logic [BWID-1:0]      ov_eng_data,
    output logic                 o_eng_nd,
    output logic                 o_eng_head,
    output logic                 o_eng_tail,
    input  logic                 i_eng_dv,
    output logic                 o_dv,
    output logic [IDW-1:0]       ov_id,
    output logic                 o_trunc,
    output logic                 o_err,
    output logic [IDW-1:0]       ov_err_id
);
    localparam logic [BWID_INDEX-1:0] MAXLEN = '1;

    typedef enum logic [2:0] {IDLE, HEAD, BODY, DRAIN, WAIT_DV} state_t;

    state_t                state, state_n;
    logic [NREQ-1:0]       gnt_n, rot;
    logic [IDW-1:0]        gid, gid_n, ptr, ptr_n, pick, off, gid_inc;
    logic [IDW:0]          sum;
    logic [BWID_INDEX-1:0] cnt, cnt_n, cnt_inc;
    logic [BWID-1:0]       sel_data;
    logic                  trunc, trunc_n, seen, seen_n;
    logic                  nd_n, head_n, tail_n, err_n;
    logic                  hit, active, acc, sel_last, owner;

    // rotate requests so the scan always starts at the pointer
    always_comb begin
        rot = NREQ'({iv_req, iv_req} >> ptr);
        hit = 1'b0;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) begin
                hit = 1'b1;
                off = IDW'(i);
            end
        sum  = {1'b0, ptr} + {1'b0, off};
        pick = (sum >= NREQ) ? IDW'(sum - NREQ) : IDW'(sum);
    end

    assign gid_inc  = (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
    assign sel_data = iv_data[gid*BWID +: BWID];
    assign sel_last = iv_last[gid];
    assign active   = (state == HEAD) || (state == BODY) || (state == DRAIN);
    assign acc      = active && iv_valid[gid];
    assign ov_ready = active ? ov_gnt : '0;
    assign cnt_inc  = cnt + 1'b1;

    // a result already reported during DRAIN must not be reported again
    assign owner    = ((state == BODY) || (state == DRAIN) || (state == WAIT_DV)) && !seen;
    assign o_dv     = i_eng_dv && owner;
    assign ov_id    = o_dv ? gid : '0;
    assign o_trunc  = o_dv && trunc;

    always_comb begin
        state_n = state;
        gnt_n   = ov_gnt;
        gid_n   = gid;
        ptr_n   = ptr;
        cnt_n   = cnt;
        trunc_n = trunc;
        seen_n  = seen || o_dv;
        nd_n    = 1'b0;
        head_n  = 1'b0;
        tail_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (hit) begin
                gnt_n   = NREQ'(1) << pick;
                gid_n   = pick;
                state_n = HEAD;
            end
            HEAD: if (acc) begin
                if (sel_last) begin
                    err_n   = 1'b1;
                    gnt_n   = '0;
                    ptr_n   = gid_inc;
                    state_n = IDLE;
                end else begin
                    nd_n    = 1'b1;
                    head_n  = 1'b1;
                    cnt_n   = BWID_INDEX'(1);
                    state_n = BODY;
                end
            end
            BODY: if (acc) begin
                nd_n  = 1'b1;
                cnt_n = cnt_inc;
                if (sel_last) begin
                    tail_n  = 1'b1;
                    state_n = WAIT_DV;
                end else if (cnt_inc == MAXLEN) begin
                    tail_n  = 1'b1;
                    trunc_n = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: if (acc && sel_last) state_n = WAIT_DV;
            WAIT_DV: if (seen || i_eng_dv) begin
                gnt_n   = '0;
                trunc_n = 1'b0;
                seen_n  = 1'b0;
                ptr_n   = gid_inc;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            ov_gnt      <= '0;
            gid         <= '0;
            ptr         <= '0;
            cnt         <= '0;
            trunc       <= 1'b0;
            seen        <= 1'b0;
            o_eng_nd    <= 1'b0;
            o_eng_head  <= 1'b0;
            o_eng_tail  <= 1'b0;
            ov_eng_data <= '0;
            o_err       <= 1'b0;
            ov_err_id   <= '0;
        end else begin
            state       <= state_n;
            ov_gnt      <= gnt_n;
            gid         <= gid_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            trunc       <= trunc_n;
            seen        <= seen_n;
            o_eng_nd    <= nd_n;
            o_eng_head  <= head_n;
            o_eng_tail  <= tail_n;
            ov_eng_data <= nd_n ? sel_data : ov_eng_data;
            o_err       <= err_n;
            ov_err_id   <= err_n ? gid : '0;
        end
    end
endmodule

// File: tb/tb_xmaxmin_sched.sv
// tb_xmaxmin_sched: scoreboard bench for the round-robin max/min engine scheduler,
// with a small engine model that answers each tail with a delayed result strobe.
module tb_xmaxmin_sched;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int BWID   = 16;
    localparam int BWI    = 3;
    localparam int MAXLEN = (1 << BWI) - 1;
    localparam int DLY    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      iv_req, ov_gnt, iv_valid, iv_last, ov_ready;
    logic [NREQ*BWID-1:0] iv_data;
    logic [BWID-1:0]      ov_eng_data;
    logic                 o_eng_nd, o_eng_head, o_eng_tail, o_dv, o_trunc, o_err;
    logic                 i_eng_dv = 1'b0;
    logic [IDW-1:0]       ov_id, ov_err_id;

    logic                 req_r [NREQ];
    logic                 valid_r [NREQ];
    logic                 last_r [NREQ];
    logic [BWID-1:0]      data_r [NREQ];
    logic [BWID-1:0]      pat [4] = '{16'd5, 16'hFFFD, 16'd9, 16'd2};

    logic [BWID+1:0]      beat_q [$];
    logic [IDW:0]         res_q [$];
    logic [IDW-1:0]       err_q [$];
    logic [NREQ-1:0]      gnt_q [$];

    int                   n_tests = 0;
    int                   n_fail = 0;
    int                   eng_cnt = 0;
    logic                 spur = 1'b0;
    logic                 prev_acc = 1'b0;
    logic                 open = 1'b0;
    logic [NREQ-1:0]      prev_gnt = '0;

    xmaxmin_sched #(.NREQ(NREQ), .IDW(IDW), .BWID(BWID), .BWID_INDEX(BWI)) dut (
        .clk(clk), .i_rst_n(rst_n), .iv_req(iv_req), .ov_gnt(ov_gnt),
        .iv_data(iv_data), .iv_valid(iv_valid), .iv_last(iv_last), .ov_ready(ov_ready),
        .ov_eng_data(ov_eng_data), .o_eng_nd(o_eng_nd), .o_eng_head(o_eng_head),
        .o_eng_tail(o_eng_tail), .i_eng_dv(i_eng_dv), .o_dv(o_dv), .ov_id(ov_id),
        .o_trunc(o_trunc), .o_err(o_err), .ov_err_id(ov_err_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            iv_req[n]   = req_r[n];
            iv_valid[n] = valid_r[n];
            iv_last[n]  = last_r[n];
            iv_data[n*BWID +: BWID] = data_r[n];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // engine model: result strobe DLY cycles after the tail, plus an optional stray strobe
    initial forever begin
        @(posedge clk);
        #1;
        i_eng_dv = spur;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) i_eng_dv = 1'b1;
        end
        if (o_eng_nd && o_eng_tail) eng_cnt = DLY;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_acc = 1'b0;
            prev_gnt = '0;
            open     = 1'b0;
        end else begin
            if (o_eng_nd) begin
                check("nd_after_accept", prev_acc, 1);
                if (beat_q.size() == 0) check("nd_unexpected", 1, 0);
                else check("eng_beat", {ov_eng_data, o_eng_head, o_eng_tail}, beat_q.pop_front());
            end else if (o_eng_head || o_eng_tail)
                check("strobe_without_nd", {o_eng_head, o_eng_tail}, 0);
            if ((ov_ready & ~ov_gnt) != 0) check("ready_not_granted", ov_ready, ov_gnt);
            if (o_dv) begin
                check("dv_coincident", i_eng_dv, 1);
                if (res_q.size() == 0) check("dv_unexpected", 1, 0);
                else check("result_id_trunc", {ov_id, o_trunc}, res_q.pop_front());
                open = 1'b0;
            end
            if (o_err) begin
                if (err_q.size() == 0) check("err_unexpected", 1, 0);
                else check("err_id", ov_err_id, err_q.pop_front());
                open = 1'b0;
            end
            if (ov_gnt != prev_gnt && ov_gnt != 0) begin
                check("gnt_while_busy", {prev_gnt != 0, open}, 0);
                if (gnt_q.size() == 0) check("gnt_unexpected", ov_gnt, 0);
                else check("gnt_order", ov_gnt, gnt_q.pop_front());
                open = 1'b1;
            end
            prev_acc = |(ov_ready & iv_valid);
            prev_gnt = ov_gnt;
        end
    end

    task automatic send(input int id, input int n, input int stall_at, input bit drop, input int base);
        int t;
        logic [BWID-1:0] d;
        req_r[id] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ov_gnt[id] && t < 400);
        if (!ov_gnt[id]) begin
            check("gnt_timeout", id, 99);
            req_r[id] = 1'b0;
            return;
        end
        if (n == 1) err_q.push_back(IDW'(id));
        else res_q.push_back({IDW'(id), n > MAXLEN});
        @(posedge clk);
        #1;
        if (drop) req_r[id] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                valid_r[id] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            d = (base < 0) ? pat[k % 4] : BWID'(base + k * 37);
            data_r[id]  = d;
            valid_r[id] = 1'b1;
            last_r[id]  = (k == n - 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!ov_ready[id] && t < 100);
            if (!ov_ready[id]) begin
                check("ready_timeout", id, 99);
                break;
            end
            if (n > 1 && k < MAXLEN) beat_q.push_back({d, k == 0, (k == n - 1) || (k == MAXLEN - 1)});
            @(posedge clk);
            #1;
        end
        valid_r[id] = 1'b0;
        last_r[id]  = 1'b0;
        t = 0;
        while (ov_gnt[id] && t < 100) begin @(negedge clk); t++; end
        if (ov_gnt[id]) check("gnt_release_timeout", id, 99);
    endtask

    initial begin
        int t;
        logic [BWID-1:0] d;
        for (int n = 0; n < NREQ; n++) begin
            req_r[n] = 1'b0;
            valid_r[n] = 1'b0;
            last_r[n] = 1'b0;
            data_r[n] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {ov_gnt, ov_ready, ov_eng_data, o_eng_nd, o_eng_head, o_eng_tail,
                                o_dv, ov_id, o_trunc, o_err, ov_err_id}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // all four requesting: 0,1,2,3 then back to 0
        gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
        for (int n = 0; n < NREQ; n++) req_r[n] = 1'b1;
        fork
            begin send(0, 3, -1, 0, 100); send(0, 3, -1, 0, 200); end
            send(1, 3, -1, 0, 300);
            send(2, 3, -1, 0, 400);
            send(3, 3, -1, 0, 500);
        join
        for (int n = 0; n < NREQ; n++) req_r[n] = 1'b0;

        // req0 alone, frame 5,-3,9,2
        gnt_q.push_back(4'b0001);
        send(0, 4, -1, 1, -1);

        // stray engine result while idle
        spur = 1'b1;
        @(negedge clk);
        check("stray_dv_ignored", o_dv, 0);
        spur = 1'b0;

        // single-beat frame from req2 dropped; req3 follows
        gnt_q.push_back(4'b0100); gnt_q.push_back(4'b1000);
        fork
            send(2, 1, -1, 1, 600);
            send(3, 3, -1, 1, 700);
        join

        // 10-beat frame truncated at 7
        gnt_q.push_back(4'b0010);
        send(1, 10, -1, 1, 800);

        // req0 stalls mid-frame while req1 waits
        gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010);
        fork
            send(0, 5, 2, 1, 900);
            begin repeat (3) @(posedge clk); #1; send(1, 3, -1, 1, 1000); end
        join

        // asynchronous reset in BODY
        gnt_q.push_back(4'b1000);
        req_r[3] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ov_gnt[3] && t < 100);
        check("rst_test_gnt", ov_gnt, 4'b1000);
        @(posedge clk);
        #1;
        req_r[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = BWID'(16'h1000 + k);
            data_r[3]  = d;
            valid_r[3] = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!ov_ready[3] && t < 100);
            beat_q.push_back({d, k == 0, 1'b0});
            @(posedge clk);
            #1;
        end
        valid_r[3] = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", ov_gnt, 0);
        check("async_rst_nd_data", {o_eng_nd, ov_eng_data}, 0);
        check("async_rst_others", {ov_ready, o_eng_head, o_eng_tail, o_dv, ov_id, o_trunc, o_err, ov_err_id}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt_q.push_back(4'b0010); gnt_q.push_back(4'b1000);
        fork
            send(1, 3, -1, 1, 1100);
            send(3, 3, -1, 1, 1200);
        join

        repeat (20) @(negedge clk);
        check("beats_left", beat_q.size(), 0);
        check("results_left", res_q.size(), 0);
        check("errs_left", err_q.size(), 0);
        check("grants_left", gnt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule

// File: doc/xmaxmin_sched.md
Name: xmaxmin_sched

Overview:
- Round-robin scheduler that shares one serial max/min search engine between NREQ streaming requesters.
- Grants one requester per frame and streams its beats into the engine as registered nd/head/tail strobes.
- Enforces the engine's frame-length limits and reports which requester owns each engine result.
- Sits between the capture channels and the single xmaxminsearch instance; the engine's value/index outputs bypass this block.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester-ID width; must satisfy 2^IDW >= NREQ.
- BWID, 16, sample width.
- BWID_INDEX, 10, engine index width; maximum forwarded frame length MAXLEN = 2^BWID_INDEX-1.

Ports:
- clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- iv_req  in  NREQ  per-requester frame request.
- ov_gnt  out  NREQ  one-hot grant, held for the whole frame.
- iv_data  in  NREQ*BWID  packed sample buses; requester n occupies bits [n*BWID +: BWID].
- iv_valid  in  NREQ  per-requester beat valid.
- iv_last  in  NREQ  per-requester last beat of frame.
- ov_ready  out  NREQ  per-requester beat accept.
- ov_eng_data  out  BWID  engine sample.
- o_eng_nd  out  1  engine new-data strobe.
- o_eng_head  out  1  engine frame start.
- o_eng_tail  out  1  engine frame end.
- i_eng_dv  in  1  engine result valid.
- o_dv  out  1  result-valid pulse, coincident with i_eng_dv.
- ov_id  out  IDW  owner of the current result.
- o_trunc  out  1  the current result covers a truncated frame.
- o_err  out  1  one-cycle pulse: a frame of length 1 was dropped.
- ov_err_id  out  IDW  requester of the dropped frame.

Behaviour:
- Reset (i_rst_n low, asynchronous) clears every output and internal register to 0.
  - State returns to IDLE and the round-robin pointer to 0.
  - Reset mid-frame abandons the frame; the engine sees no tail.
- Beat transfer: a beat is accepted when ov_ready[g] and iv_valid[g] are both high; g is the granted index.
- ov_ready[g] is high only in HEAD, BODY and DRAIN; it is 0 for all non-granted requesters.
- Engine strobes and ov_eng_data are registered: each lands exactly 1 cycle after the accepted beat.
- IDLE:
  - Scan iv_req starting at the pointer, wrapping modulo NREQ.
  - On the first set bit, register a one-hot ov_gnt and go to HEAD.
  - No request: stay in IDLE.
- HEAD: on an accepted beat,
  - If iv_last is low: drive nd=1, head=1, tail=0; set count=1; go to BODY.
  - If iv_last is high (length 1, which the engine cannot process):
    - Do not forward the beat.
    - Next cycle: pulse o_err with ov_err_id=g.
    - Advance the pointer to g+1 and go to IDLE.
- BODY: on an accepted beat, drive nd=1 and increment count.
  - If iv_last is high: tail=1; go to WAIT_DV.
  - Else if count+1 == MAXLEN: force tail=1, set trunc_flag, go to DRAIN.
- DRAIN:
  - Accept and discard beats (no engine strobes) until a beat with iv_last, then go to WAIT_DV.
  - If i_eng_dv arrives while in DRAIN, latch the result report and emit it at that cycle.
- WAIT_DV:
  - On i_eng_dv: o_dv=1, ov_id=g, o_trunc=trunc_flag.
  - Then clear ov_gnt and trunc_flag, set pointer=g+1 mod NREQ, go to IDLE.
  - The result is reported exactly once per frame.
- Grant rules:
  - Grant is never revoked early; deasserting iv_req mid-frame is ignored until the frame completes.
  - iv_valid gaps insert engine idle cycles (nd=0); the frame is unaffected.
- i_eng_dv received outside BODY/DRAIN/WAIT_DV is ignored; o_dv stays 0.
- Throughput: at most one frame in flight. Minimum 2 idle cycles between frames (WAIT_DV, IDLE).

Test Plan:
- Req0 only, frame [5,-3,9,2] with last on 4th beat, ov_gnt=0001 -> engine sees head+nd on beat 1, tail on beat 4, each 1 cycle later; o_dv pulses on the engine's dv with ov_id=0, o_trunc=0.
- iv_req=1111 held constant, every frame 3 beats -> grants issued in order 0,1,2,3,0; each produces o_dv with the matching ov_id.
- Req2 sends a single beat with last=1 -> no engine strobes; o_err pulses once with ov_err_id=2; next grant goes to req3 if it is requesting.
- BWID_INDEX=3 (MAXLEN=7), req1 sends a 10-beat frame -> engine gets 7 nd beats with tail on the 7th; beats 8-10 are accepted and dropped; o_dv has ov_id=1, o_trunc=1.
- Req0 stalls iv_valid for 3 cycles mid-frame while req1 requests -> o_eng_nd is low during the stall, grant stays on req0, req1 is granted only after req0's o_dv.
- Assert i_rst_n low in BODY -> all outputs are 0 immediately (asynchronous); after release, state is IDLE and the next grant starts from requester 0.
